hazard_fwd_ctrl: RTL and testbench
==================================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Pipeline hazard/forwarding controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
//  Keeps its own scoreboard of in-flight destinations, from ID-stage decode info.
//  Drives PC/IF_ID write enables, ID/EX bubble insertion, EX operand forward selects and WB->ID bypass.
//  Also handles the external pipeline hold.
// PARAMETERS
//  ADDR_W  5   register address width
//  CNT_W   16  width of saturating stall-cycle counter
// PORTS
//  clk          in  1       clock, rising edge
//  rst          in  1       synchronous, active-high reset
//  id_valid     in  1       ID holds a real instruction (0 = bubble)
//  id_rs_addr   in  ADDR_W  ID rs field [25:21]
//  id_rt_addr   in  ADDR_W  ID rt field [20:16]
//  id_uses_rs   in  1       ID instr reads rs
//  id_uses_rt   in  1       ID instr reads rt (R-type, sw)
//  id_reg_write in  1       ID instr writes RF
//  id_mem_read  in  1       ID instr is a load
//  id_dst_addr  in  ADDR_W  resolved dest (RegDst ? rd : rt)
//  ext_hold     in  1       freeze whole pipeline (e.g. DM not ready)
//  pc_write     out 1       PC update enable
//  if_id_write  out 1       IF/ID register enable
//  pipe_en      out 1       ID/EX, EX/MEM, MEM/WB register enable
//  id_ex_flush  out 1       load bubble (zero WB/M/EX controls) into ID/EX
//  fwd_a_sel    out 2       EX Src1 mux: 00 ID/EX, 01 EX/MEM result, 10 MEM/WB Rd_Data
//  fwd_b_sel    out 2       EX Rt-data mux, same encoding (applied before ALUSrc mux)
//  wb_byp_a     out 1       ID: replace Rs_Data with Rd_Data (WB writes same reg this cycle)
//  wb_byp_b     out 1       ID: replace Rt_Data with Rd_Data
//  stall_cnt    out CNT_W   cycles spent in STALL, saturating
// BEHAVIOUR
//  - Scoreboard: 3 entries EX/MEM/WB, each {wr, ld, dst}. Entry with dst==0 is treated as wr=0.
//    With pipe_en=1: WB<=MEM, MEM<=EX.
//    EX<=ID info when there is no stall and id_valid=1; otherwise EX<=invalid.
//  - Match(X,a,uses): uses && X.wr && X.dst==a && a!=0.
//  - Hazard (HAZARD_FWD_EN defined): haz = id_valid && EX.ld && (Match(EX,rs) || Match(EX,rt)).
//  - FSM {RUN, STALL, HOLD}:
//    - ext_hold=1 -> HOLD from any state (priority over haz).
//    - RUN, haz -> STALL. STALL, !haz -> RUN.
//    - HOLD, !ext_hold -> (haz ? STALL : RUN).
//  - Outputs are combinational from state/haz:
//    - HOLD (or ext_hold): pc_write=if_id_write=pipe_en=0, id_ex_flush=0; scoreboard, fwd sels, counter frozen.
//    - haz, no hold: pc_write=if_id_write=0, pipe_en=1, id_ex_flush=1.
//    - else: all enables 1, id_ex_flush=0.
//  - Forward selects are registered. On a pipe_en cycle with no stall:
//    - fwd_x_sel <= Match(EX) ? 01 : Match(MEM) ? 10 : 00.
//    - EX has priority (youngest producer wins).
//    - On a bubble cycle the selects load 00.
//  - wb_byp_x = Match(WB,addr,uses) && id_valid; combinational.
//  - stall_cnt increments each cycle with id_ex_flush=1; it holds at 2^CNT_W-1.
//  - Reset (rst=1): scoreboard invalid, state RUN, fwd sels 00, stall_cnt 0.
//    While rst is high: pc_write=if_id_write=0, pipe_en=1, id_ex_flush=1 (drains bubbles).
//    Reset mid-stall abandons the stall.
//  - Stall latency: a load-use costs exactly 1 bubble. Back-to-back loads each evaluate independently.
// CONFIGURATION
//  HAZARD_FWD_EN defined: forwarding + WB bypass as above.
//  HAZARD_FWD_EN undefined:
//    - fwd_*_sel tied 00, wb_byp_* tied 0.
//    - haz = id_valid && any Match(EX|MEM|WB) on rs/rt (load or not).
//    - Up to 3 bubbles per dependency.
// STRUCTURE
//  hazard_pkg: FWD_ID_EX=2'b00, FWD_EX_MEM=2'b01, FWD_MEM_WB=2'b10; hz_state_t enum; sb_entry_t struct {wr,ld,dst}.
//  Sub-module hazard_scoreboard: the 3-entry shift register plus Match comparators.
//  The FSM, forward registers and counter live in the top.
// TESTING
//  1 lw $2,0($1); add $3,$2,$4 -> one cycle: pc_write=0, id_ex_flush=1. Next cycle add in EX with fwd_a_sel=10. stall_cnt=1.
//  2 add $2,$1,$1; sub $5,$2,$2 -> no stall; in sub's EX fwd_a_sel=fwd_b_sel=01.
//  3 add $2; nop; nop; or $6,$2,$0 -> or in ID while add in WB: wb_byp_a=1, no stall, fwd sels 00.
//  4 lw $0,.. then add $3,$0,$0 -> no stall, no forward, wb_byp 0 (zero-register rule).
//  5 load-use with ext_hold=1 for 3 cycles at the stall cycle -> all enables 0, stall_cnt unchanged while held.
//    After release, exactly 1 bubble is issued.
//    rst pulse during a stall -> state RUN, sels 00, stall_cnt 0 next cycle.
//  6 HAZARD_FWD_EN undefined: add $2,..; add $3,$2,$2 -> 3 consecutive bubbles, then issue, sels 00.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the hazard/forwarding controller.
//   FWD_* : EX operand mux encodings (00 ID/EX, 01 EX/MEM, 10 MEM/WB)
//   hz_state_t : controller FSM states
//   sb_entry_t : one scoreboard slot {wr, ld, dst}
//   sb_match() : producer/consumer register match, $0 never matches
package hazard_pkg;

  localparam int HZ_ADDR_W = 5;

  localparam logic [1:0] FWD_ID_EX  = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HOLD  = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic                 wr;
    logic                 ld;
    logic [HZ_ADDR_W-1:0] dst;
  } sb_entry_t;

  localparam sb_entry_t SB_INVALID = '{wr: 1'b0, ld: 1'b0, dst: '0};

  function automatic logic sb_match(input sb_entry_t e,
                                    input logic [HZ_ADDR_W-1:0] a,
                                    input logic uses);
    return uses && e.wr && (e.dst == a) && (a != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: ID-stage decode info in, pipeline control out.
//   master : pipeline side (drives id_* and ext_hold, receives controls)
//   slave  : hazard_fwd_ctrl side
interface hazard_fwd_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [ADDR_W-1:0] id_dst_addr;
  logic              ext_hold;

  logic              pc_write;
  logic              if_id_write;
  logic              pipe_en;
  logic              id_ex_flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              wb_byp_a;
  logic              wb_byp_b;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
           id_reg_write, id_mem_read, id_dst_addr, ext_hold,
    input  pc_write, if_id_write, pipe_en, id_ex_flush,
           fwd_a_sel, fwd_b_sel, wb_byp_a, wb_byp_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
           id_reg_write, id_mem_read, id_dst_addr, ext_hold,
    output pc_write, if_id_write, pipe_en, id_ex_flush,
           fwd_a_sel, fwd_b_sel, wb_byp_a, wb_byp_b, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl_scoreboard.sv
// hazard_scoreboard: 3-slot shadow of the EX/MEM/WB destinations plus the
// rs/rt comparators against the instruction currently in ID.
//   clk, rst        : clock, synchronous active-high reset
//   i_shift         : advance the pipe (pipe_en)
//   i_issue         : ID instruction enters EX this cycle (else a bubble)
//   i_id_entry      : ID {wr, ld, dst}
//   i_rs/rt_addr    : ID source registers, i_uses_rs/rt qualify them
//   o_ex_ld         : EX slot holds a load
//   o_m_<stage>_<s> : source s matches the producer in <stage>
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_shift,
  input  logic                 i_issue,
  input  sb_entry_t            i_id_entry,
  input  logic [HZ_ADDR_W-1:0] i_rs_addr,
  input  logic [HZ_ADDR_W-1:0] i_rt_addr,
  input  logic                 i_uses_rs,
  input  logic                 i_uses_rt,
  output logic                 o_ex_ld,
  output logic                 o_m_ex_rs,
  output logic                 o_m_ex_rt,
  output logic                 o_m_mem_rs,
  output logic                 o_m_mem_rt,
  output logic                 o_m_wb_rs,
  output logic                 o_m_wb_rt
);
  sb_entry_t r_ex, r_mem, r_wb;
  sb_entry_t w_id_norm;

  // Writes to $0 are discarded at entry so they can never look like producers.
  always_comb begin
    w_id_norm     = i_id_entry;
    w_id_norm.wr  = i_id_entry.wr && (i_id_entry.dst != '0);
    w_id_norm.ld  = i_id_entry.ld && w_id_norm.wr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= SB_INVALID;
      r_mem <= SB_INVALID;
      r_wb  <= SB_INVALID;
    end else if (i_shift) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= i_issue ? w_id_norm : SB_INVALID;
    end
  end

  assign o_ex_ld    = r_ex.ld;
  assign o_m_ex_rs  = sb_match(r_ex,  i_rs_addr, i_uses_rs);
  assign o_m_ex_rt  = sb_match(r_ex,  i_rt_addr, i_uses_rt);
  assign o_m_mem_rs = sb_match(r_mem, i_rs_addr, i_uses_rs);
  assign o_m_mem_rt = sb_match(r_mem, i_rt_addr, i_uses_rt);
  assign o_m_wb_rs  = sb_match(r_wb,  i_rs_addr, i_uses_rs);
  assign o_m_wb_rt  = sb_match(r_wb,  i_rt_addr, i_uses_rt);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use / RAW hazard detection, EX forwarding selects,
// WB->ID bypass and external pipeline hold for the 5-stage MIPS core.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (drains bubbles while high)
//   bus  : hazard_fwd_ctrl_if.slave (ID decode info, ext_hold in;
//          pc_write, if_id_write, pipe_en, id_ex_flush, fwd_a/b_sel,
//          wb_byp_a/b, stall_cnt out)
// Build option: HAZARD_FWD_EN enables forwarding and WB bypass; without it
// every RAW dependency on EX/MEM/WB stalls until the producer has retired.
//
// state | meaning
// RUN   | normal issue
// STALL | bubble(s) being inserted for a pending dependency
// HOLD  | whole pipeline frozen by ext_hold
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W = HZ_ADDR_W,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_fwd_ctrl_if.slave bus
);
  hz_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [ADDR_W-1:0] w_rs_addr, w_rt_addr;
  sb_entry_t         w_id_entry;
  logic w_ex_ld;
  logic w_m_ex_rs, w_m_ex_rt, w_m_mem_rs, w_m_mem_rt, w_m_wb_rs, w_m_wb_rt;
  logic w_haz, w_issue;
  logic w_pc_write, w_if_id_write, w_pipe_en, w_id_ex_flush;

  assign w_rs_addr  = bus.id_rs_addr;
  assign w_rt_addr  = bus.id_rt_addr;
  assign w_id_entry = '{wr: bus.id_reg_write, ld: bus.id_mem_read, dst: bus.id_dst_addr};

  hazard_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_shift    (w_pipe_en),
    .i_issue    (w_issue),
    .i_id_entry (w_id_entry),
    .i_rs_addr  (w_rs_addr),
    .i_rt_addr  (w_rt_addr),
    .i_uses_rs  (bus.id_uses_rs),
    .i_uses_rt  (bus.id_uses_rt),
    .o_ex_ld    (w_ex_ld),
    .o_m_ex_rs  (w_m_ex_rs),
    .o_m_ex_rt  (w_m_ex_rt),
    .o_m_mem_rs (w_m_mem_rs),
    .o_m_mem_rt (w_m_mem_rt),
    .o_m_wb_rs  (w_m_wb_rs),
    .o_m_wb_rt  (w_m_wb_rt)
  );

`ifdef HAZARD_FWD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign w_haz = bus.id_valid && w_ex_ld && (w_m_ex_rs || w_m_ex_rt);
`else
  assign w_haz = bus.id_valid && (w_m_ex_rs || w_m_ex_rt || w_m_mem_rs ||
                                  w_m_mem_rt || w_m_wb_rs || w_m_wb_rt);
  logic w_unused_nofwd;
  assign w_unused_nofwd = w_ex_ld;
`endif

  assign w_issue = bus.id_valid && !w_haz;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.ext_hold) begin
      w_state_nxt = HOLD;
    end else begin
      case (r_state)
        RUN:     if (w_haz)  w_state_nxt = STALL;
        STALL:   if (!w_haz) w_state_nxt = RUN;
        HOLD:    w_state_nxt = w_haz ? STALL : RUN;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // The release cycle (state HOLD, ext_hold low) is still frozen; the
  // pending hazard is re-evaluated from STALL on the following cycle.
  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_pipe_en     = 1'b1;
    w_id_ex_flush = 1'b0;
    if (rst) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
    end else if (r_state == HOLD || bus.ext_hold) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_pipe_en     = 1'b0;
    end else if (w_haz) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_id_ex_flush && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] r_fwd_a_sel, r_fwd_b_sel;

  // Selects are for the instruction moving ID->EX: its producer now in EX
  // will sit in EX/MEM, one in MEM will sit in MEM/WB. Youngest wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_a_sel <= FWD_ID_EX;
      r_fwd_b_sel <= FWD_ID_EX;
    end else if (w_pipe_en) begin
      if (w_issue) begin
        r_fwd_a_sel <= w_m_ex_rs ? FWD_EX_MEM : (w_m_mem_rs ? FWD_MEM_WB : FWD_ID_EX);
        r_fwd_b_sel <= w_m_ex_rt ? FWD_EX_MEM : (w_m_mem_rt ? FWD_MEM_WB : FWD_ID_EX);
      end else begin
        r_fwd_a_sel <= FWD_ID_EX;
        r_fwd_b_sel <= FWD_ID_EX;
      end
    end
  end

  assign bus.fwd_a_sel = r_fwd_a_sel;
  assign bus.fwd_b_sel = r_fwd_b_sel;
  assign bus.wb_byp_a  = bus.id_valid && w_m_wb_rs;
  assign bus.wb_byp_b  = bus.id_valid && w_m_wb_rt;
`else
  assign bus.fwd_a_sel = FWD_ID_EX;
  assign bus.fwd_b_sel = FWD_ID_EX;
  assign bus.wb_byp_a  = 1'b0;
  assign bus.wb_byp_b  = 1'b0;
`endif

  assign bus.pc_write    = w_pc_write;
  assign bus.if_id_write = w_if_id_write;
  assign bus.pipe_en     = w_pipe_en;
  assign bus.id_ex_flush = w_id_ex_flush;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.ADDR_W(5), .CNT_W(16)) bus ();
  hazard_fwd_ctrl_if #(.ADDR_W(5), .CNT_W(2))  bus_s ();

  hazard_fwd_ctrl #(.ADDR_W(5), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  hazard_fwd_ctrl #(.ADDR_W(5), .CNT_W(2))  u_sat (.clk(clk), .rst(rst), .bus(bus_s));

  assign bus_s.id_valid     = bus.id_valid;
  assign bus_s.id_rs_addr   = bus.id_rs_addr;
  assign bus_s.id_rt_addr   = bus.id_rt_addr;
  assign bus_s.id_uses_rs   = bus.id_uses_rs;
  assign bus_s.id_uses_rt   = bus.id_uses_rt;
  assign bus_s.id_reg_write = bus.id_reg_write;
  assign bus_s.id_mem_read  = bus.id_mem_read;
  assign bus_s.id_dst_addr  = bus.id_dst_addr;
  assign bus_s.ext_hold     = bus.ext_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic rw, input logic mr,
                     input logic [4:0] dst);
    bus.id_valid     = v;
    bus.id_rs_addr   = rs;
    bus.id_rt_addr   = rt;
    bus.id_uses_rs   = urs;
    bus.id_uses_rt   = urt;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_dst_addr  = dst;
    #1;
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ext_hold = 1'b0;
    nop();
    tick();
    rst = 1'b0;
    nop();
  endtask

  // lw $2,0($1)
  task automatic drv_lw2();
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
  endtask

  // add $3,$2,$4
  task automatic drv_use2();
    drv(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ext_hold = 1'b0;
    rst = 1'b1;
    nop();
    chk("rst_pc_write", bus.pc_write, 1'b0);
    chk("rst_if_id_write", bus.if_id_write, 1'b0);
    chk("rst_pipe_en", bus.pipe_en, 1'b1);
    chk("rst_flush", bus.id_ex_flush, 1'b1);
    tick();
    tick();
    chk("rst_cnt", bus.stall_cnt, 16'd0);
    rst = 1'b0;
    nop();
    chk("idle_pc_write", bus.pc_write, 1'b1);
    chk("idle_flush", bus.id_ex_flush, 1'b0);
    chk("idle_fwd_a", bus.fwd_a_sel, 2'b00);
    chk("idle_fwd_b", bus.fwd_b_sel, 2'b00);
    chk("idle_byp_a", bus.wb_byp_a, 1'b0);

    // 1: lw $2 ; add $3,$2,$4
    do_reset();
    drv_lw2();
    chk("t1_lw_pc", bus.pc_write, 1'b1);
    tick();
    drv_use2();
    chk("t1_stall_pc", bus.pc_write, 1'b0);
    chk("t1_stall_ifid", bus.if_id_write, 1'b0);
    chk("t1_stall_pipe", bus.pipe_en, 1'b1);
    chk("t1_stall_flush", bus.id_ex_flush, 1'b1);
    tick();
`ifdef HAZARD_FWD_EN
    chk("t1_issue_pc", bus.pc_write, 1'b1);
    chk("t1_issue_flush", bus.id_ex_flush, 1'b0);
    chk("t1_cnt", bus.stall_cnt, 16'd1);
    tick();
    nop();
    chk("t1_fwd_a", bus.fwd_a_sel, 2'b10);
    chk("t1_fwd_b", bus.fwd_b_sel, 2'b00);
    chk("t1_cnt_after", bus.stall_cnt, 16'd1);
`else
    chk("t1_bubble2_pc", bus.pc_write, 1'b0);
    tick();
    chk("t1_bubble3_flush", bus.id_ex_flush, 1'b1);
    chk("t1_cnt2", bus.stall_cnt, 16'd2);
    tick();
    chk("t1_issue_pc", bus.pc_write, 1'b1);
    chk("t1_cnt", bus.stall_cnt, 16'd3);
    tick();
    nop();
    chk("t1_fwd_a", bus.fwd_a_sel, 2'b00);
`endif

    // 2: add $2,$1,$1 ; sub $5,$2,$2
    do_reset();
    drv(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2);
    tick();
    drv(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
`ifdef HAZARD_FWD_EN
    chk("t2_pc", bus.pc_write, 1'b1);
    chk("t2_flush", bus.id_ex_flush, 1'b0);
    tick();
    nop();
    chk("t2_fwd_a", bus.fwd_a_sel, 2'b01);
    chk("t2_fwd_b", bus.fwd_b_sel, 2'b01);
    chk("t2_cnt", bus.stall_cnt, 16'd0);
`else
    chk("t2_b1_pc", bus.pc_write, 1'b0);
    tick();
    chk("t2_b2_pc", bus.pc_write, 1'b0);
    tick();
    chk("t2_b3_flush", bus.id_ex_flush, 1'b1);
    tick();
    chk("t2_issue_pc", bus.pc_write, 1'b1);
    chk("t2_cnt", bus.stall_cnt, 16'd3);
    tick();
    nop();
    chk("t2_fwd_a", bus.fwd_a_sel, 2'b00);
    chk("t2_fwd_b", bus.fwd_b_sel, 2'b00);
`endif

    // 3: add $2 ; nop ; nop ; or $6,$2,$0
    do_reset();
    drv(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2);
    tick();
    nop();
    chk("t3_nop_pc", bus.pc_write, 1'b1);
    tick();
    nop();
    tick();
    drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
`ifdef HAZARD_FWD_EN
    chk("t3_byp_a", bus.wb_byp_a, 1'b1);
    chk("t3_byp_b", bus.wb_byp_b, 1'b0);
    chk("t3_pc", bus.pc_write, 1'b1);
    tick();
    nop();
    chk("t3_fwd_a", bus.fwd_a_sel, 2'b00);
    chk("t3_fwd_b", bus.fwd_b_sel, 2'b00);
`else
    chk("t3_byp_a", bus.wb_byp_a, 1'b0);
    chk("t3_wb_stall_pc", bus.pc_write, 1'b0);
    tick();
    chk("t3_issue_pc", bus.pc_write, 1'b1);
    tick();
    nop();
    chk("t3_fwd_a", bus.fwd_a_sel, 2'b00);
    chk("t3_cnt", bus.stall_cnt, 16'd1);
`endif

    // 4: lw $0 ; add $3,$0,$0
    do_reset();
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
    tick();
    drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    chk("t4_pc", bus.pc_write, 1'b1);
    chk("t4_flush", bus.id_ex_flush, 1'b0);
    chk("t4_byp_a", bus.wb_byp_a, 1'b0);
    tick();
    nop();
    chk("t4_fwd_a", bus.fwd_a_sel, 2'b00);
    chk("t4_fwd_b", bus.fwd_b_sel, 2'b00);
    chk("t4_cnt", bus.stall_cnt, 16'd0);

    // 5: load-use with ext_hold for 3 cycles at the stall cycle
    do_reset();
    drv_lw2();
    tick();
    bus.ext_hold = 1'b1;
    drv_use2();
    chk("t5_h1_pc", bus.pc_write, 1'b0);
    chk("t5_h1_ifid", bus.if_id_write, 1'b0);
    chk("t5_h1_pipe", bus.pipe_en, 1'b0);
    chk("t5_h1_flush", bus.id_ex_flush, 1'b0);
    tick();
    chk("t5_h2_pipe", bus.pipe_en, 1'b0);
    chk("t5_h2_cnt", bus.stall_cnt, 16'd0);
    tick();
    chk("t5_h3_flush", bus.id_ex_flush, 1'b0);
    tick();
    bus.ext_hold = 1'b0;
    #1;
    chk("t5_rel_pipe", bus.pipe_en, 1'b0);
    chk("t5_rel_pc", bus.pc_write, 1'b0);
    chk("t5_rel_cnt", bus.stall_cnt, 16'd0);
    tick();
    chk("t5_bub_pc", bus.pc_write, 1'b0);
    chk("t5_bub_pipe", bus.pipe_en, 1'b1);
    chk("t5_bub_flush", bus.id_ex_flush, 1'b1);
    tick();
`ifdef HAZARD_FWD_EN
    chk("t5_issue_pc", bus.pc_write, 1'b1);
    chk("t5_cnt", bus.stall_cnt, 16'd1);
`else
    chk("t5_bub2_flush", bus.id_ex_flush, 1'b1);
    tick();
    tick();
    chk("t5_issue_pc", bus.pc_write, 1'b1);
    chk("t5_cnt", bus.stall_cnt, 16'd3);
`endif

    // 5b: reset pulse in the middle of a stall
    do_reset();
    drv_lw2();
    tick();
    drv_use2();
    chk("t5r_stall_flush", bus.id_ex_flush, 1'b1);
    tick();
    chk("t5r_cnt_pre", bus.stall_cnt, 16'd1);
    rst = 1'b1;
    #1;
    chk("t5r_rst_pc", bus.pc_write, 1'b0);
    chk("t5r_rst_flush", bus.id_ex_flush, 1'b1);
    tick();
    rst = 1'b0;
    nop();
    chk("t5r_cnt", bus.stall_cnt, 16'd0);
    chk("t5r_fwd_a", bus.fwd_a_sel, 2'b00);
    chk("t5r_fwd_b", bus.fwd_b_sel, 2'b00);
    chk("t5r_pc", bus.pc_write, 1'b1);
    chk("t5r_flush", bus.id_ex_flush, 1'b0);

    // Counter saturation: four load-use pairs into a 16-bit and a 2-bit counter
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv_lw2();
      tick();
      drv_use2();
      repeat (4) tick();
    end
    nop();
`ifdef HAZARD_FWD_EN
    chk("sat_cnt16", bus.stall_cnt, 16'd4);
`else
    chk("sat_cnt16", bus.stall_cnt, 16'd12);
`endif
    chk("sat_cnt2", bus_s.stall_cnt, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
